div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one div_sp divider (legal values 1..16).
REQ-002 Parameter STRT_HOLD, default 3: cycles div_strt is held high per job (must be >= 1).
REQ-003 Parameter DIV_LATENCY, default 40: cycles after div_strt falls until div_z is valid (must be >= 1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester request level.
REQ-007 a_in  input  32*N_REQ  dividend operands (IEEE-754 single); requester i uses bits [32i+31:32i].
REQ-008 b_in  input  32*N_REQ  divisor operands, packed the same way as a_in.
REQ-009 gnt  output  N_REQ  one-hot, one-cycle pulse: operands of requester i accepted.
REQ-010 done  output  N_REQ  one-hot, one-cycle pulse: z_out holds requester i's result.
REQ-011 z_out  output  32  registered quotient.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 div_strt  output  1  drives the divider strt input.
REQ-014 div_a / div_b  output  32 each  registered operands to the divider.
REQ-015 div_z  input  32  divider result.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT and DONE, plus a round-robin pointer ptr (log2 N_REQ bits).
REQ-017 IDLE, some req bit high: select the first set bit scanning ptr, ptr+1, ... with wrap mod N_REQ; latch its a/b into div_a/div_b; go to ISSUE.
REQ-018 IDLE, req all zero: stay in IDLE; all outputs keep their values except the pulses, which are 0.
REQ-019 First ISSUE cycle: gnt[sel]=1 for exactly that cycle.
REQ-020 ISSUE lasts exactly STRT_HOLD cycles with div_strt=1, then the FSM goes to WAIT.
REQ-021 WAIT lasts exactly DIV_LATENCY cycles with div_strt=0, then the FSM goes to DONE.
REQ-022 DONE lasts one cycle: z_out<=div_z; done[sel]=1 that cycle; ptr<=(sel+1) mod N_REQ; next state IDLE.
REQ-023 Timing: req sampled in IDLE at edge t gives gnt high during cycle t+1 and done high during cycle t+1+STRT_HOLD+DIV_LATENCY.
REQ-024 div_a/div_b SHALL stay constant from ISSUE through DONE; a_in/b_in changes after gnt have no effect on the job.
REQ-025 Requests SHALL NOT queue: a req bit dropped before its gnt is forgotten.
REQ-026 A req bit still high after its done counts as a new request.
REQ-027 Back-to-back jobs: at least one IDLE cycle between a DONE and the next ISSUE.
REQ-028 z_out SHALL hold its last result until the next DONE.
REQ-029 gnt and done SHALL never be high in the same cycle, and each SHALL have at most one bit set.
REQ-030 The block SHALL NOT inspect or modify operand or result values (no special-case handling of NaN or zero).

Reset
REQ-031 reset low, asynchronously: state=IDLE, ptr=0, gnt=0, done=0, z_out=0, div_a=0, div_b=0, div_strt=0, busy=0.
REQ-032 Reset in ISSUE or WAIT SHALL abort the job: no done is generated for it, and div_strt drops immediately.
REQ-033 First arbitration after reset release: the first rising edge with reset high, starting the scan from requester 0.

Verification
REQ-034 Single job: req=4'b0001, a=0x40C00000 (6.0), b=0x40000000 (2.0) -> gnt=0001 at t+1; div_strt high for 3 cycles; done=0001 at t+44; z_out=0x40400000.
REQ-035 Fairness: req=4'b1111 held continuously -> gnt order 0,1,2,3,0, each job separated by DONE and one IDLE cycle.
REQ-036 Pointer wrap: last grant went to 2, req=4'b1011 -> next gnt=1000, then 0001.
REQ-037 Reset abort: assert reset 10 cycles into WAIT -> div_strt=0, busy=0, z_out=0 at once; no done pulse; a new job after release completes normally.
REQ-038 Dropped request: while busy, pulse req[1] for 2 cycles -> gnt[1] never asserts; operand change after gnt leaves div_a/div_b unchanged through DONE.
REQ-039 Bench SHALL check REQ-029 on every cycle using a behavioural divider model with latency DIV_LATENCY.

Source files
------------

// File: rtl/div_sched.sv
// Round-robin scheduler that shares one multi-cycle divider among N_REQ requesters.
// Operands are latched at grant; the quotient is captured into z_out as the job completes.
module div_sched #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned STRT_HOLD   = 3,
    parameter int unsigned DIV_LATENCY = 40
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [32*N_REQ-1:0]   i_a_in,
    input  logic [32*N_REQ-1:0]   i_b_in,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_done,
    output logic [31:0]           o_z_out,
    output logic                  o_busy,
    output logic                  o_div_strt,
    output logic [31:0]           o_div_a,
    output logic [31:0]           o_div_b,
    input  logic [31:0]           i_div_z
);

    localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PW1  = PW + 1;
    localparam int unsigned MAXC = (STRT_HOLD > DIV_LATENCY) ? STRT_HOLD : DIV_LATENCY;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic [PW-1:0]   r_ptr, r_sel, w_sel, w_off;
    logic [PW:0]     w_sum;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_div_a, r_div_b, r_z;
    logic [31:0]     w_a, w_b;
    logic [N_REQ-1:0] w_rot;
    logic            w_any;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        w_rot = N_REQ'({i_req, i_req} >> r_ptr);
        w_any = |w_rot;
        w_off = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = PW'(i);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= PW1'(N_REQ)) w_sum = w_sum - PW1'(N_REQ);
        w_sel = w_sum[PW-1:0];
        w_a   = '0;
        w_b   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_sel == PW'(i)) begin
                w_a = i_a_in[32*i +: 32];
                w_b = i_b_in[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_any) w_state_nxt = StIssue;
            StIssue: if (r_cnt == CW'(STRT_HOLD - 1)) w_state_nxt = StWait;
            StWait:  if (r_cnt == CW'(DIV_LATENCY - 1)) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_sel   <= w_sel;
                        r_div_a <= w_a;
                        r_div_b <= w_b;
                        r_cnt   <= '0;
                    end
                end
                StIssue: begin
                    if (r_cnt == CW'(STRT_HOLD - 1)) r_cnt <= '0;
                    else                             r_cnt <= r_cnt + 1'b1;
                end
                StWait: begin
                    // Capture on entry to DONE so z_out is already valid while done pulses.
                    if (r_cnt == CW'(DIV_LATENCY - 1)) begin
                        r_cnt <= '0;
                        r_z   <= i_div_z;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (r_sel == PW'(N_REQ - 1)) r_ptr <= '0;
                    else                         r_ptr <= r_sel + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        o_gnt  = '0;
        o_done = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (r_sel == PW'(i)) begin
                o_gnt[i]  = (r_state == StIssue) && (r_cnt == '0);
                o_done[i] = (r_state == StDone);
            end
        end
    end

    assign o_busy     = (r_state != StIdle);
    assign o_div_strt = (r_state == StIssue);
    assign o_div_a    = r_div_a;
    assign o_div_b    = r_div_b;
    assign o_z_out    = r_z;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural divider (valid DIV_LATENCY cycles after strt falls).
// Also checks on every cycle that gnt/done are mutually exclusive and at most one-hot.
module tb_div_sched;

    localparam int N   = 4;
    localparam int SH  = 3;
    localparam int LAT = 40;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [31:0]   av [N];
    logic [31:0]   bv [N];
    logic [32*N-1:0] a_in, b_in;
    logic [N-1:0]  gnt, done;
    logic [31:0]   z_out, div_a, div_b, div_z;
    logic          busy, div_strt;

    int n_cmp = 0;
    int n_err = 0;

    assign a_in = {av[3], av[2], av[1], av[0]};
    assign b_in = {bv[3], bv[2], bv[1], bv[0]};

    div_sched #(
        .N_REQ       (N),
        .STRT_HOLD   (SH),
        .DIV_LATENCY (LAT)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_a_in     (a_in),
        .i_b_in     (b_in),
        .o_gnt      (gnt),
        .o_done     (done),
        .o_z_out    (z_out),
        .o_busy     (busy),
        .o_div_strt (div_strt),
        .o_div_a    (div_a),
        .o_div_b    (div_b),
        .i_div_z    (div_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Normal single-precision values only; result truncated back to single.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'b0) d = {f[31], 63'b0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'b0) return {d[63], 31'b0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    logic [31:0] m_res = 32'h0;
    int          m_cnt = 0;

    always @(negedge clk) begin
        if (div_strt) begin
            m_res <= r2f(f2r(div_a) / f2r(div_b));
            m_cnt <= 0;
        end else if (m_cnt < LAT) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign div_z = (m_cnt >= LAT) ? m_res : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        check("gnt_done_onehot",
              32'(((|gnt) && (|done)) || !$onehot0(gnt) || !$onehot0(done)), 32'h0);
    end

    task automatic wait_for(input string tag, input bit on_done, input logic [N-1:0] exp_v,
                            input int budget, output int cycles);
        logic [N-1:0] v;
        cycles = 0;
        v = on_done ? done : gnt;
        while (v == '0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
            v = on_done ? done : gnt;
        end
        check(tag, 32'(v), 32'(exp_v));
    endtask

    // Expects gnt one cycle after the current negedge, then the full strt/wait/done sequence.
    task automatic do_job(input int idx, input logic [31:0] exp_z, input logic [N-1:0] req_after);
        int c;
        wait_for("gnt", 1'b0, N'(1 << idx), 60, c);
        check("gnt_latency", 32'(c), 32'd1);
        req = req_after;
        for (int k = 0; k < SH; k++) begin
            check("strt_high", 32'(div_strt), 32'd1);
            @(negedge clk);
        end
        check("strt_low", 32'(div_strt), 32'd0);
        wait_for("done", 1'b1, N'(1 << idx), 60, c);
        check("done_latency", 32'(c + SH), 32'(SH + LAT));
        check("z_out", z_out, exp_z);
        @(negedge clk);
        check("idle_gap", 32'(busy), 32'd0);
        check("z_hold", z_out, exp_z);
    endtask

    initial begin
        int c, nd, ng, bad;
        logic [31:0] ez [N];
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_gnt",   32'(gnt), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        check("rst_z",     z_out, 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_strt",  32'(div_strt), 32'h0);
        check("rst_div_a", div_a, 32'h0);
        check("rst_div_b", div_b, 32'h0);

        av[0] = 32'h40C0_0000; bv[0] = 32'h4000_0000; ez[0] = 32'h4040_0000; // 6/2
        av[1] = 32'h3F80_0000; bv[1] = 32'h4080_0000; ez[1] = 32'h3E80_0000; // 1/4
        av[2] = 32'h4120_0000; bv[2] = 32'h4080_0000; ez[2] = 32'h4020_0000; // 10/4
        av[3] = 32'hC100_0000; bv[3] = 32'h4000_0000; ez[3] = 32'hC080_0000; // -8/2

        rst_n = 1'b1;
        @(negedge clk);
        req = 4'b0001;
        do_job(0, ez[0], 4'b0000);

        // Fairness from a fresh reset: scan starts at requester 0.
        rst_n = 1'b0;
        req = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            do_job(j % N, ez[j % N], (j == 4) ? 4'b0000 : 4'b1111);
        end

        // Pointer wrap: last grant to 2, then 1011 gives 3 then 0.
        req = 4'b0100;
        do_job(2, ez[2], 4'b0000);
        req = 4'b1011;
        do_job(3, ez[3], 4'b1011);
        do_job(0, ez[0], 4'b0000);

        // Reset in the 10th WAIT cycle aborts the job.
        req = 4'b0010;
        wait_for("abort_gnt", 1'b0, 4'b0010, 60, c);
        req = 4'b0000;
        repeat (SH + 9) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_strt", 32'(div_strt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_z",    z_out, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            if (done != '0) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        req = 4'b0001;
        do_job(0, ez[0], 4'b0000);

        // Dropped request and operand change after grant.
        req = 4'b0100;
        wait_for("drop_gnt", 1'b0, 4'b0100, 60, c);
        check("drop_gnt_latency", 32'(c), 32'd1);
        check("drop_div_a", div_a, 32'h4120_0000);
        req   = 4'b0000;
        av[2] = 32'h7FC0_0000;
        bv[2] = 32'h0000_0000;
        ng  = 0;
        bad = 0;
        @(negedge clk);
        req = 4'b0010;
        repeat (2) begin
            @(negedge clk);
            if (gnt[1]) ng++;
        end
        req = 4'b0000;
        c = 0;
        while (done == '0 && c < 60) begin
            if (div_a !== 32'h4120_0000 || div_b !== 32'h4080_0000) bad++;
            @(negedge clk);
            c++;
            if (gnt[1]) ng++;
        end
        check("drop_done", 32'(done), 32'h4);
        check("drop_done_latency", 32'(c + 3), 32'(SH + LAT));
        check("drop_ops_stable", 32'(bad), 32'd0);
        check("drop_ops_at_done", div_a, 32'h4120_0000);
        check("drop_z", z_out, 32'h4020_0000);
        repeat (5) begin
            @(negedge clk);
            if (gnt[1]) ng++;
        end
        check("drop_no_gnt1", 32'(ng), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
